// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader.
package prog_loader_pkg;

    // Default upper nibble expected in the header byte.
    localparam logic [3:0] MAGIC_DFLT = 4'hA;

    // Width of the record counter (N-1 fits in a nibble).
    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        ADDR  = 3'd2,
        DATA  = 3'd3,
        WRITE = 3'd4,
        CSUM  = 3'd5,
        RUN   = 3'd6,
        ERR   = 3'd7
    } state_t;

    // States that consume stream bytes.
    function automatic logic ready_of(input state_t s);
        return (s == HDR) || (s == ADDR) || (s == DATA) || (s == CSUM);
    endfunction

    // States during which the CPU must be held off.
    function automatic logic busy_of(input state_t s);
        return (s == HDR) || (s == ADDR) || (s == DATA) || (s == WRITE) || (s == CSUM);
    endfunction

endpackage

// File: rtl/prog_loader.sv
// Streams {addr,data} records into program RAM, validates header and checksum,
// then enables the instruction counter on success.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter logic [3:0] MAGIC = MAGIC_DFLT
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       start,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       PR,
    output logic [3:0] AddrM,
    output logic [7:0] Prog,
    output logic       busy,
    output logic       run,
    output logic       err
);

    state_t           state;
    state_t           nxt;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       acc;
    logic             xfer;

    // in_ready is registered from the next state, so it always reflects the current state
    assign xfer = in_valid & in_ready;

    // Next-state decode; only a completed handshake advances the byte-consuming states
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (start) nxt = HDR;
            HDR:     if (xfer)  nxt = (in_data[7:4] == MAGIC) ? ADDR : ERR;
            ADDR:    if (xfer)  nxt = (in_data[7:4] == 4'h0) ? DATA : ERR;
            DATA:    if (xfer)  nxt = WRITE;
            WRITE:              nxt = (cnt != '0) ? ADDR : CSUM;
            CSUM:    if (xfer)  nxt = (in_data == acc) ? RUN : ERR;
            RUN,
            ERR:     if (start) nxt = HDR;
            default:            nxt = IDLE;
        endcase
    end

    // State, registered outputs, address/data latches, checksum and record counter
    always_ff @(posedge clk) begin
        if (clr) begin
            state    <= IDLE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            PR       <= 1'b0;
            run      <= 1'b0;
            err      <= 1'b0;
            AddrM    <= 4'h0;
            Prog     <= 8'h00;
            acc      <= 8'h00;
            cnt      <= '0;
        end else begin
            state    <= nxt;
            in_ready <= ready_of(nxt);
            busy     <= busy_of(nxt);
            PR       <= (nxt == WRITE);
            run      <= (nxt == RUN);
            err      <= (nxt == ERR);
            case (state)
                IDLE, RUN, ERR: begin
                    // a new load starts with a fresh checksum
                    if (start) acc <= 8'h00;
                end
                HDR: begin
                    if (xfer) cnt <= in_data[CNT_W-1:0];
                end
                ADDR: begin
                    if (xfer && in_data[7:4] == 4'h0) begin
                        acc   <= acc + in_data;
                        AddrM <= in_data[3:0];
                    end
                end
                DATA: begin
                    if (xfer) begin
                        acc  <= acc + in_data;
                        Prog <= in_data;
                    end
                end
                WRITE: begin
                    cnt <= cnt - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: a scoreboard queue holds the expected RAM
// writes, and a negedge monitor pops and checks one entry per PR pulse.
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       clr;
    logic       start;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       PR;
    logic [3:0] AddrM;
    logic [7:0] Prog;
    logic       busy;
    logic       run;
    logic       err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [11:0] sbq[$];
    logic        prev_pr = 1'b0;

    prog_loader #(.MAGIC(4'hA)) dut (
        .clk      (clk),
        .clr      (clr),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .PR       (PR),
        .AddrM    (AddrM),
        .Prog     (Prog),
        .busy     (busy),
        .run      (run),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every PR pulse must be a single cycle and match the head of the scoreboard.
    always @(negedge clk) begin
        if (PR === 1'b1) begin
            check("pr_single_cycle", 32'(prev_pr), 32'd0);
            check("pr_expected", 32'(sbq.size() != 0), 32'd1);
            if (sbq.size() != 0) begin
                logic [11:0] e;
                e = sbq.pop_front();
                check("pr_addr", 32'(AddrM), 32'(e[11:8]));
                check("pr_data", 32'(Prog), 32'(e[7:0]));
            end
        end
        prev_pr = PR;
    end

    // Expect every record in the stream (header at [0]) to be written in order.
    task automatic push_records(input logic [7:0] bs[$], input int nrec);
        for (int i = 0; i < nrec; i++)
            sbq.push_back({bs[1 + 2*i][3:0], bs[2 + 2*i]});
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Present one byte and hold it until the loader takes it (bounded wait).
    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("handshake_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
    endtask

    // Send a byte list; gap=1 inserts random idle cycles between bytes.
    task automatic send_list(input logic [7:0] bs[$], input int gap);
        for (int i = 0; i < bs.size(); i++) begin
            send_byte(bs[i]);
            if (gap != 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_pr"},    32'(PR),       32'd0);
        check({tag, "_rdy"},   32'(in_ready), 32'd0);
        check({tag, "_busy"},  32'(busy),     32'd0);
        check({tag, "_run"},   32'(run),      32'd0);
        check({tag, "_err"},   32'(err),      32'd0);
        check({tag, "_addrm"}, 32'(AddrM),    32'd0);
        check({tag, "_prog"},  32'(Prog),     32'd0);
    endtask

    task automatic check_done(input string tag, input logic exp_run, input logic exp_err);
        check({tag, "_run"},  32'(run),      32'(exp_run));
        check({tag, "_err"},  32'(err),      32'(exp_err));
        check({tag, "_busy"}, 32'(busy),     32'd0);
        check({tag, "_rdy"},  32'(in_ready), 32'd0);
        check({tag, "_sb"},   32'(sbq.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] bs[$];
        clr = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        clr = 1'b0;
        @(negedge clk);

        // Normal load, in_valid held high through every WRITE cycle
        do_start();
        check("start_busy", 32'(busy), 32'd1);
        check("start_rdy",  32'(in_ready), 32'd1);
        bs = '{8'hA5, 8'h00, 8'h1E, 8'h01, 8'h2F, 8'h02, 8'hE0,
               8'h03, 8'hF0, 8'h0E, 8'h0F, 8'h0F, 8'h0B, 8'h5A};
        push_records(bs, 6);
        send_list(bs, 0);
        check_done("normal", 1'b1, 1'b0);

        // Bad magic, started directly from RUN
        do_start();
        check("rerun_run_clr", 32'(run), 32'd0);
        check("rerun_busy", 32'(busy), 32'd1);
        bs = '{8'h35};
        send_list(bs, 0);
        check_done("badmagic", 1'b0, 1'b1);

        // Bad checksum, started from ERR: the one record is still written
        do_start();
        check("restart_err_clr", 32'(err), 32'd0);
        bs = '{8'hA0, 8'h04, 8'h99, 8'h00};
        push_records(bs, 1);
        send_list(bs, 0);
        check_done("badcsum", 1'b0, 1'b1);

        // Bad address byte
        do_start();
        bs = '{8'hA0, 8'h13};
        send_list(bs, 0);
        check_done("badaddr", 1'b0, 1'b1);

        // Gapped stream with a repeated address (both writes issued, in order)
        do_start();
        bs = '{8'hA1, 8'h05, 8'h11, 8'h05, 8'h22, 8'h3D};
        push_records(bs, 2);
        send_list(bs, 1);
        check_done("gaps", 1'b1, 1'b0);

        // Reset mid-load after the second record's address byte; start mid-load is ignored
        do_start();
        bs = '{8'hA1};
        send_list(bs, 0);
        do_start();
        check("midstart_busy", 32'(busy), 32'd1);
        bs = '{8'h00, 8'h10, 8'h01};
        sbq.push_back({4'h0, 8'h10});
        send_list(bs, 0);
        clr = 1'b1;
        @(negedge clk);
        check_idle_outputs("midclr");
        clr = 1'b0;
        repeat (4) @(negedge clk);
        check("midclr_sb", 32'(sbq.size()), 32'd0);
        check("midclr_idle_busy", 32'(busy), 32'd0);

        // Reload after reset
        do_start();
        bs = '{8'hA5, 8'h00, 8'h1E, 8'h01, 8'h2F, 8'h02, 8'hE0,
               8'h03, 8'hF0, 8'h0E, 8'h0F, 8'h0F, 8'h0B, 8'h5A};
        push_records(bs, 6);
        send_list(bs, 1);
        check_done("reload", 1'b1, 1'b0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter MAGIC, default 4'hA: required upper nibble of the header byte.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 clr  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request to begin a load; level-sampled.
REQ-005 in_data  input  8  stream byte.
REQ-006 in_valid  input  1  in_data is valid this cycle.
REQ-007 in_ready  output  1  loader accepts in_data this cycle.
REQ-008 PR  output  1  RAM program-write strobe.
REQ-009 AddrM  output  4  RAM program address.
REQ-010 Prog  output  8  RAM program data.
REQ-011 busy  output  1  load in progress; holds CPU clear/stall externally.
REQ-012 run  output  1  enable for the instruction step counter (IC) after a good load.
REQ-013 err  output  1  last load failed; sticky until next start or clr.

Function
REQ-014 A byte transfers on a rising edge where in_valid and in_ready are both 1; no other edge consumes a byte.
REQ-015 Stream format SHALL be: header byte, then N records of {address byte, data byte}, then one checksum byte.
REQ-016 Header: upper nibble SHALL equal MAGIC; lower nibble = N-1 (N = 1..16).
REQ-017 Address byte: upper nibble SHALL be 0; lower nibble = RAM address.
REQ-018 Checksum: 8-bit modulo-256 sum of all record bytes (header excluded).
REQ-019 States: IDLE, HDR, ADDR, DATA, WRITE, CSUM, RUN, ERR.
REQ-020 in_ready = 1 only in HDR, ADDR, DATA, CSUM.
REQ-021 busy = 1 in HDR, ADDR, DATA, WRITE, CSUM.
REQ-022 IDLE: start=1 -> HDR; clears err and the checksum accumulator.
REQ-023 HDR: byte accepted with good magic -> ADDR, record counter loaded with N-1; bad magic -> ERR.
REQ-024 ADDR: byte accepted with upper nibble 0 -> DATA, AddrM latched; otherwise -> ERR.
REQ-025 DATA: byte accepted -> WRITE, Prog latched.
REQ-026 WRITE: PR = 1 for exactly this one cycle, with AddrM/Prog stable.
REQ-027 WRITE exit: -> ADDR if records remain, else -> CSUM; counter decrements.
REQ-028 CSUM: byte accepted equal to the accumulator -> RUN; unequal -> ERR (err=1).
REQ-029 Writes already issued are not undone on a later error.
REQ-030 RUN: run = 1, held until start or clr.
REQ-031 start in RUN or ERR -> HDR, with run and err cleared on the same edge.
REQ-032 start in HDR..CSUM is ignored.
REQ-033 in_valid is ignored when in_ready = 0; in WRITE the byte stays pending and is taken in the next ADDR.
REQ-034 A repeated address overwrites (last write wins).
REQ-035 Minimum record latency: 3 cycles (ADDR, DATA, WRITE).

Reset
REQ-036 clr = 1 at a rising edge -> IDLE, including mid-load.
REQ-037 Same edge: PR, in_ready, busy, run, err = 0; AddrM = 0, Prog = 0, accumulator = 0, counter = 0.
REQ-038 clr has priority over start and over any handshake on that edge.

Structure
REQ-039 Shared package prog_loader_pkg holds the state enum, the default MAGIC, and the record-count width (4).
REQ-040 Single module; the checksum accumulator and record counter stay inline, with no sub-module.

Verification
REQ-041 Normal load: start; A5, 00 1E, 01 2F, 02 E0, 03 F0, 0E 0F, 0F 0B, then 5A -> six single-cycle PR pulses at addresses 0,1,2,3,E,F with matching Prog; run=1, err=0.
REQ-042 Bad magic: header 35 -> ERR, err=1, no PR pulse, in_ready=0.
REQ-043 Bad checksum: header A0, record 04 99, checksum 00 -> one PR pulse (addr 4, data 99), then err=1, run=0.
REQ-044 Bad address byte: A0 then 13 -> err=1, no PR pulse.
REQ-045 Backpressure: in_valid held high continuously across WRITE -> no byte lost or duplicated; in_valid gaps just stall the loader.
REQ-046 Reset mid-load: clr after the second record's address byte -> next edge IDLE, all outputs 0, no further PR pulse; a new start reloads correctly.
